// File: rtl/sto_ctrl.sv
// STO estimation sequencer: counter start, sample gating, window flush/commit.
// Optional watchdog enabled by defining STO_CTRL_TIMEOUT_EN.
module sto_ctrl #(
  parameter int FLUSH_LAT = 2,
  parameter int WIN_W     = 12,
  parameter int TIMEOUT   = 8191
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             func_valid,
  input  logic             inc_nofdm,
  input  logic             cnt_done,
  output logic             in_valid,
  output logic             cnt_starter,
  output logic             accu_rst,
  output logic             accu_ld,
  output logic             mf_rst,
  output logic             mf_en,
  output logic             sto_calc_en,
  output logic             busy,
  output logic             done,
  output logic [WIN_W-1:0] win_cnt,
  output logic             err
);

  localparam int FW = (FLUSH_LAT > 1) ? $clog2(FLUSH_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_FLUSH,
    S_CMP,
    S_CALC,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [FW-1:0] fl_cnt;
  logic          last;
  logic          tmo;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fl_cnt  <= '0;
      last    <= 1'b0;
      win_cnt <= '0;
    end else begin
      unique case (state)
        S_INIT: begin
          win_cnt <= '0;
          last    <= 1'b0;
        end
        S_RUN: begin
          if (cnt_done)  last   <= 1'b1;
          if (inc_nofdm) fl_cnt <= FW'(FLUSH_LAT - 1);
        end
        S_FLUSH: begin
          if (cnt_done)      last   <= 1'b1;
          if (fl_cnt != '0)  fl_cnt <= fl_cnt - 1'b1;
        end
        S_CMP: begin
          if (~&win_cnt) win_cnt <= win_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef STO_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_cnt;

  // INIT is cycle 0 of a run; err fires on cycle TIMEOUT
  always_ff @(posedge clk) begin
    if (rst)                 wd_cnt <= '0;
    else if (state == S_INIT) wd_cnt <= '0;
    else if (busy)           wd_cnt <= wd_cnt + 1'b1;
  end

  assign tmo = busy && (state != S_INIT)
            && (wd_cnt == TW'(TIMEOUT - 1));
`else
  assign tmo = (TIMEOUT < 0);
`endif

  assign err = tmo;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_INIT;
      S_INIT:  state_nx = S_RUN;
      S_RUN:   if (inc_nofdm) state_nx = S_FLUSH;
      S_FLUSH: if (fl_cnt == '0) state_nx = S_CMP;
      S_CMP:   state_nx = (last || cnt_done) ? S_CALC : S_RUN;
      S_CALC:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (tmo) state_nx = S_IDLE;
  end

  always_comb begin
    sample_ready = 1'b0;
    cnt_starter  = 1'b0;
    accu_rst     = 1'b0;
    accu_ld      = 1'b0;
    mf_rst       = 1'b0;
    mf_en        = 1'b0;
    sto_calc_en  = 1'b0;
    done         = 1'b0;
    busy         = (state != S_IDLE);
    unique case (state)
      S_INIT: begin
        cnt_starter = 1'b1;
        accu_rst    = 1'b1;
        mf_rst      = 1'b1;
      end
      S_RUN: begin
        sample_ready = 1'b1;
        accu_ld      = func_valid;
      end
      S_FLUSH: accu_ld = func_valid;
      // min finder samples accu_out before the clear lands
      S_CMP: begin
        mf_en    = 1'b1;
        accu_rst = 1'b1;
      end
      S_CALC:  sto_calc_en = ~tmo;
      S_DONE:  done        = ~tmo;
      default: ;
    endcase
    in_valid = sample_valid & sample_ready;
  end

endmodule

// File: tb/tb_sto_ctrl.sv
// Directed bench for sto_ctrl: reset, windows, flush gating, busy start,
// simultaneous boundary/done and (with STO_CTRL_TIMEOUT_EN) the watchdog.
module tb_sto_ctrl;

  localparam int FL = 2;
  localparam int WW = 12;
`ifdef STO_CTRL_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 8191;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sample_valid;
  logic          sample_ready;
  logic          func_valid;
  logic          inc_nofdm;
  logic          cnt_done;
  logic          in_valid;
  logic          cnt_starter;
  logic          accu_rst;
  logic          accu_ld;
  logic          mf_rst;
  logic          mf_en;
  logic          sto_calc_en;
  logic          busy;
  logic          done;
  logic [WW-1:0] win_cnt;
  logic          err;

  sto_ctrl #(.FLUSH_LAT(FL), .WIN_W(WW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .func_valid(func_valid), .inc_nofdm(inc_nofdm),
    .cnt_done(cnt_done), .in_valid(in_valid),
    .cnt_starter(cnt_starter), .accu_rst(accu_rst),
    .accu_ld(accu_ld), .mf_rst(mf_rst), .mf_en(mf_en),
    .sto_calc_en(sto_calc_en), .busy(busy), .done(done),
    .win_cnt(win_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int n_mf = 0, n_cs = 0, n_calc = 0, n_done = 0, n_err = 0;
  int n_inv = 0, n_rstbad = 0;
  int calc_cyc = 0, done_cyc = 0, err_cyc = 0;
  int mf_cyc [64];

  always @(negedge clk) begin
    if (mf_en) begin
      mf_cyc[n_mf % 64] = cyc;
      n_mf++;
      if (!accu_rst) n_rstbad++;
    end
    if (cnt_starter) n_cs++;
    if (in_valid) n_inv++;
    if (sto_calc_en) begin n_calc++; calc_cyc = cyc; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (err) begin n_err++; err_cyc = cyc; end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic window(input int n, input bit cd, output int inc_cyc);
    sample_valid = 1'b1;
    repeat (n) tick();
    sample_valid = 1'b0;
    inc_nofdm = 1'b1;
    cnt_done  = cd;
    inc_cyc   = cyc;
    tick();
    inc_nofdm = 1'b0;
    cnt_done  = 1'b0;
    repeat (FL + 1) tick();
  endtask

  task automatic test_reset;
    logic [10:0] o;
    int b_done, x;
    rst = 1'b1; start = 0; sample_valid = 0; func_valid = 0;
    inc_nofdm = 0; cnt_done = 0;
    repeat (3) tick();
    o = {sample_ready, in_valid, cnt_starter, accu_rst, accu_ld,
         mf_rst, mf_en, sto_calc_en, busy, done, err};
    n_cmp++; if (o !== 11'b0) begin n_bad++; $display("FAIL reset_outs: got %b want 0", o); end
    n_cmp++; if (win_cnt !== '0) begin n_bad++; $display("FAIL reset_win: got %0d want 0", win_cnt); end
    rst = 1'b0;
    tick();
    b_done = n_done;
    do_start();
    window(8, 1'b0, x);
    n_cmp++; if (win_cnt !== 12'd1) begin n_bad++; $display("FAIL pre_rst_win: got %0d want 1", win_cnt); end
    sample_valid = 1'b1;
    func_valid   = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    o = {sample_ready, in_valid, cnt_starter, accu_rst, accu_ld,
         mf_rst, mf_en, sto_calc_en, busy, done, err};
    n_cmp++; if (o !== 11'b0) begin n_bad++; $display("FAIL midrun_rst_outs: got %b want 0", o); end
    n_cmp++; if (win_cnt !== '0) begin n_bad++; $display("FAIL midrun_rst_win: got %0d want 0", win_cnt); end
    rst = 1'b0;
    sample_valid = 1'b0;
    func_valid   = 1'b0;
    repeat (4) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrun_rst_busy: got %b want 0", busy); end
    n_cmp++; if (n_done - b_done != 0) begin n_bad++; $display("FAIL midrun_rst_done: got %0d want 0", n_done - b_done); end
  endtask

  task automatic test_ignored;
    inc_nofdm  = 1'b1;
    func_valid = 1'b1;
    repeat (2) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_inc_busy: got %b want 0", busy); end
    n_cmp++; if (accu_ld !== 1'b0) begin n_bad++; $display("FAIL idle_accu_ld: got %b want 0", accu_ld); end
    inc_nofdm  = 1'b0;
    func_valid = 1'b0;
    tick();
  endtask

  task automatic test_normal;
    int b_mf, b_cs, b_calc, b_done, b_inv;
    int i0, i1, i2;
    b_mf = n_mf; b_cs = n_cs; b_calc = n_calc; b_done = n_done; b_inv = n_inv;
    do_start();
    window(16, 1'b0, i0);
    window(16, 1'b0, i1);
    window(16, 1'b1, i2);
    repeat (3) tick();
    n_cmp++; if (n_mf - b_mf != 3) begin n_bad++; $display("FAIL norm_mf_count: got %0d want 3", n_mf - b_mf); end
    n_cmp++; if (mf_cyc[b_mf % 64] != i0 + FL + 1) begin n_bad++; $display("FAIL norm_mf0_lat: got %0d want %0d", mf_cyc[b_mf % 64] - i0, FL + 1); end
    n_cmp++; if (mf_cyc[(b_mf + 1) % 64] != i1 + FL + 1) begin n_bad++; $display("FAIL norm_mf1_lat: got %0d want %0d", mf_cyc[(b_mf + 1) % 64] - i1, FL + 1); end
    n_cmp++; if (mf_cyc[(b_mf + 2) % 64] != i2 + FL + 1) begin n_bad++; $display("FAIL norm_mf2_lat: got %0d want %0d", mf_cyc[(b_mf + 2) % 64] - i2, FL + 1); end
    n_cmp++; if (n_rstbad != 0) begin n_bad++; $display("FAIL norm_accu_rst_with_mf: got %0d want 0", n_rstbad); end
    n_cmp++; if (n_calc - b_calc != 1) begin n_bad++; $display("FAIL norm_calc_count: got %0d want 1", n_calc - b_calc); end
    n_cmp++; if (calc_cyc != i2 + FL + 2) begin n_bad++; $display("FAIL norm_calc_cyc: got %0d want %0d", calc_cyc, i2 + FL + 2); end
    n_cmp++; if (done_cyc != i2 + FL + 3) begin n_bad++; $display("FAIL norm_done_cyc: got %0d want %0d", done_cyc, i2 + FL + 3); end
    n_cmp++; if (n_done - b_done != 1) begin n_bad++; $display("FAIL norm_done_count: got %0d want 1", n_done - b_done); end
    n_cmp++; if (win_cnt !== 12'd3) begin n_bad++; $display("FAIL norm_win_cnt: got %0d want 3", win_cnt); end
    n_cmp++; if (n_cs - b_cs != 1) begin n_bad++; $display("FAIL norm_starter: got %0d want 1", n_cs - b_cs); end
    n_cmp++; if (n_inv - b_inv != 48) begin n_bad++; $display("FAIL norm_in_valid: got %0d want 48", n_inv - b_inv); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL norm_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_flush_gating;
    int b_done, x;
    b_done = n_done;
    do_start();
    sample_valid = 1'b1;
    repeat (4) tick();
    n_cmp++; if (in_valid !== 1'b1) begin n_bad++; $display("FAIL gate_run_in_valid: got %b want 1", in_valid); end
    inc_nofdm = 1'b1;
    tick();
    inc_nofdm = 1'b0;
    n_cmp++; if (in_valid !== 1'b0) begin n_bad++; $display("FAIL gate_flush0_in_valid: got %b want 0", in_valid); end
    n_cmp++; if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL gate_flush_ready: got %b want 0", sample_ready); end
    func_valid = 1'b1;
    #1;
    n_cmp++; if (accu_ld !== 1'b1) begin n_bad++; $display("FAIL gate_flush_accu_ld: got %b want 1", accu_ld); end
    tick();
    n_cmp++; if (in_valid !== 1'b0) begin n_bad++; $display("FAIL gate_flush1_in_valid: got %b want 0", in_valid); end
    tick();
    n_cmp++; if (mf_en !== 1'b1) begin n_bad++; $display("FAIL gate_cmp_mf_en: got %b want 1", mf_en); end
    n_cmp++; if (in_valid !== 1'b0) begin n_bad++; $display("FAIL gate_cmp_in_valid: got %b want 0", in_valid); end
    n_cmp++; if (accu_ld !== 1'b0) begin n_bad++; $display("FAIL gate_cmp_accu_ld: got %b want 0", accu_ld); end
    func_valid = 1'b0;
    tick();
    n_cmp++; if (in_valid !== 1'b1) begin n_bad++; $display("FAIL gate_rerun_in_valid: got %b want 1", in_valid); end
    window(4, 1'b1, x);
    repeat (3) tick();
    n_cmp++; if (n_done - b_done != 1) begin n_bad++; $display("FAIL gate_done: got %0d want 1", n_done - b_done); end
    n_cmp++; if (win_cnt !== 12'd2) begin n_bad++; $display("FAIL gate_win_cnt: got %0d want 2", win_cnt); end
  endtask

  task automatic test_start_busy;
    int b_cs, b_done, b_mf, x;
    b_cs = n_cs; b_done = n_done; b_mf = n_mf;
    do_start();
    sample_valid = 1'b1;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL busy_start_state: got ready %b want 1", sample_ready); end
    window(8, 1'b0, x);
    window(8, 1'b1, x);
    repeat (3) tick();
    n_cmp++; if (n_cs - b_cs != 1) begin n_bad++; $display("FAIL busy_start_starter: got %0d want 1", n_cs - b_cs); end
    n_cmp++; if (n_mf - b_mf != 2) begin n_bad++; $display("FAIL busy_start_mf: got %0d want 2", n_mf - b_mf); end
    n_cmp++; if (n_done - b_done != 1) begin n_bad++; $display("FAIL busy_start_done: got %0d want 1", n_done - b_done); end
    n_cmp++; if (win_cnt !== 12'd2) begin n_bad++; $display("FAIL busy_start_win: got %0d want 2", win_cnt); end
  endtask

  task automatic test_simultaneous;
    int b_mf, b_calc, b_done, i0;
    b_mf = n_mf; b_calc = n_calc; b_done = n_done;
    do_start();
    sample_valid = 1'b1;
    repeat (5) tick();
    sample_valid = 1'b0;
    cnt_done = 1'b1;
    tick();
    cnt_done = 1'b0;
    tick();
    window(0, 1'b0, i0);
    repeat (4) tick();
    n_cmp++; if (n_mf - b_mf != 1) begin n_bad++; $display("FAIL simul_mf: got %0d want 1", n_mf - b_mf); end
    n_cmp++; if (mf_cyc[b_mf % 64] != i0 + FL + 1) begin n_bad++; $display("FAIL simul_mf_lat: got %0d want %0d", mf_cyc[b_mf % 64] - i0, FL + 1); end
    n_cmp++; if (n_calc - b_calc != 1) begin n_bad++; $display("FAIL simul_calc: got %0d want 1", n_calc - b_calc); end
    n_cmp++; if (n_done - b_done != 1) begin n_bad++; $display("FAIL simul_done: got %0d want 1", n_done - b_done); end
    n_cmp++; if (win_cnt !== 12'd1) begin n_bad++; $display("FAIL simul_win: got %0d want 1", win_cnt); end
  endtask

`ifdef STO_CTRL_TIMEOUT_EN
  task automatic test_watchdog;
    int b_err, b_done, b_calc, s;
    b_err = n_err; b_done = n_done; b_calc = n_calc;
    s = cyc;
    do_start();
    sample_valid = 1'b1;
    repeat (150) tick();
    sample_valid = 1'b0;
    n_cmp++; if (n_err - b_err != 1) begin n_bad++; $display("FAIL wd_err_count: got %0d want 1", n_err - b_err); end
    n_cmp++; if (err_cyc != s + 1 + TO) begin n_bad++; $display("FAIL wd_err_cyc: got %0d want %0d", err_cyc - s - 1, TO); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wd_busy: got %b want 0", busy); end
    n_cmp++; if (n_done - b_done != 0) begin n_bad++; $display("FAIL wd_done: got %0d want 0", n_done - b_done); end
    n_cmp++; if (n_calc - b_calc != 0) begin n_bad++; $display("FAIL wd_calc: got %0d want 0", n_calc - b_calc); end
  endtask
`endif

  initial begin
    test_reset();
    test_ignored();
    test_normal();
    test_flush_gating();
    test_start_busy();
    test_simultaneous();
`ifdef STO_CTRL_TIMEOUT_EN
    test_watchdog();
`endif
    n_cmp++; if (n_err != 0 && TO > 1000) begin n_bad++; $display("FAIL stray_err: got %0d want 0", n_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
